// File: rtl/uart_cmd_decoder.sv
// UART byte-stream to JTAG command decoder: parses opcode/length/payload frames,
// emits a header per command and a registered payload stream, and reports errors.
module uart_cmd_decoder #(
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    output logic       hdr_valid,
    input  logic       hdr_ready,
    output logic [1:0] hdr_op,
    output logic [7:0] hdr_len,
    output logic       dat_valid,
    input  logic       dat_ready,
    output logic [7:0] dat_byte,
    output logic       dat_last,
    output logic       err_valid,
    output logic [1:0] err_code
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

    localparam logic [1:0] S_OP   = 2'd0;
    localparam logic [1:0] S_LEN  = 2'd1;
    localparam logic [1:0] S_HDR  = 2'd2;
    localparam logic [1:0] S_DATA = 2'd3;

    localparam logic [1:0] OP_RESET = 2'd0;
    localparam logic [1:0] OP_IR    = 2'd1;
    localparam logic [1:0] OP_DR    = 2'd2;
    localparam logic [1:0] OP_RUN   = 2'd3;

    logic [1:0]    state_q, state_d;
    logic [1:0]    hdr_op_q, hdr_op_d;
    logic [7:0]    hdr_len_q, hdr_len_d;
    logic          hdr_valid_q, hdr_valid_d;
    logic [5:0]    cnt_q, cnt_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          dat_valid_q, dat_valid_d;
    logic [7:0]    dat_byte_q, dat_byte_d;
    logic          dat_last_q, dat_last_d;
    logic          err_valid_q, err_valid_d;
    logic [1:0]    err_code_q, err_code_d;

    logic          in_ready_s;
    logic          accept_s;
    logic          is_shift_s;
    logic [8:0]    len_round_s;

    // Upstream ready: DATA only takes a byte when the one-entry output register can move
    always_comb begin
        case (state_q)
            S_OP:    in_ready_s = 1'b1;
            S_LEN:   in_ready_s = 1'b1;
            S_HDR:   in_ready_s = 1'b0;
            S_DATA:  in_ready_s = !dat_valid_q || dat_ready;
            default: in_ready_s = 1'b0;
        endcase
    end

    assign accept_s    = in_valid && in_ready_s;
    assign is_shift_s  = (hdr_op_q == OP_IR) || (hdr_op_q == OP_DR);
    assign len_round_s = {1'b0, in_data} + 9'd7;

    // Frame parser, timeout counter and output register next-state
    always_comb begin
        state_d     = state_q;
        hdr_op_d    = hdr_op_q;
        hdr_len_d   = hdr_len_q;
        hdr_valid_d = hdr_valid_q;
        cnt_d       = cnt_q;
        tmo_d       = tmo_q;
        dat_valid_d = dat_valid_q;
        dat_byte_d  = dat_byte_q;
        dat_last_d  = dat_last_q;
        err_valid_d = 1'b0;
        err_code_d  = err_code_q;

        // A pending payload byte drains independently of the parser state
        if (dat_valid_q && dat_ready) begin
            dat_valid_d = 1'b0;
            dat_last_d  = 1'b0;
        end else begin
            dat_valid_d = dat_valid_q;
        end

        case (state_q)
            S_OP: begin
                tmo_d = '0;
                if (accept_s) begin
                    case (in_data)
                        8'h01: begin
                            hdr_op_d    = OP_RESET;
                            hdr_len_d   = 8'd0;
                            hdr_valid_d = 1'b1;
                            state_d     = S_HDR;
                        end
                        8'h02: begin
                            hdr_op_d = OP_IR;
                            state_d  = S_LEN;
                        end
                        8'h03: begin
                            hdr_op_d = OP_DR;
                            state_d  = S_LEN;
                        end
                        8'h04: begin
                            hdr_op_d = OP_RUN;
                            state_d  = S_LEN;
                        end
                        default: begin
                            err_valid_d = 1'b1;
                            err_code_d  = 2'd1;
                        end
                    endcase
                end else begin
                    state_d = S_OP;
                end
            end
            S_LEN: begin
                if (accept_s) begin
                    tmo_d     = '0;
                    hdr_len_d = in_data;
                    cnt_d     = len_round_s[8:3];
                    if (is_shift_s && (in_data == 8'd0)) begin
                        err_valid_d = 1'b1;
                        err_code_d  = 2'd2;
                        state_d     = S_OP;
                    end else begin
                        hdr_valid_d = 1'b1;
                        state_d     = S_HDR;
                    end
                end else if (tmo_q == TMO_LAST) begin
                    err_valid_d = 1'b1;
                    err_code_d  = 2'd3;
                    state_d     = S_OP;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            S_HDR: begin
                tmo_d = '0;
                if (hdr_ready) begin
                    hdr_valid_d = 1'b0;
                    state_d     = is_shift_s ? S_DATA : S_OP;
                end else begin
                    hdr_valid_d = 1'b1;
                end
            end
            S_DATA: begin
                if (accept_s) begin
                    tmo_d       = '0;
                    dat_valid_d = 1'b1;
                    dat_byte_d  = in_data;
                    dat_last_d  = (cnt_q == 6'd1);
                    cnt_d       = cnt_q - 6'd1;
                    if (cnt_q == 6'd1) begin
                        state_d = S_OP;
                    end else begin
                        state_d = S_DATA;
                    end
                end else if (in_ready_s) begin
                    // Only idle cycles with the path open count; back-pressure holds the count
                    if (tmo_q == TMO_LAST) begin
                        err_valid_d = 1'b1;
                        err_code_d  = 2'd3;
                        state_d     = S_OP;
                    end else begin
                        tmo_d = tmo_q + TW'(1);
                    end
                end else begin
                    tmo_d = tmo_q;
                end
            end
            default: begin
                state_d = S_OP;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_OP;
            hdr_op_q    <= 2'd0;
            hdr_len_q   <= 8'd0;
            hdr_valid_q <= 1'b0;
            cnt_q       <= 6'd0;
            tmo_q       <= '0;
            dat_valid_q <= 1'b0;
            dat_byte_q  <= 8'd0;
            dat_last_q  <= 1'b0;
            err_valid_q <= 1'b0;
            err_code_q  <= 2'd0;
        end else begin
            state_q     <= state_d;
            hdr_op_q    <= hdr_op_d;
            hdr_len_q   <= hdr_len_d;
            hdr_valid_q <= hdr_valid_d;
            cnt_q       <= cnt_d;
            tmo_q       <= tmo_d;
            dat_valid_q <= dat_valid_d;
            dat_byte_q  <= dat_byte_d;
            dat_last_q  <= dat_last_d;
            err_valid_q <= err_valid_d;
            err_code_q  <= err_code_d;
        end
    end

    assign in_ready  = in_ready_s;
    assign hdr_valid = hdr_valid_q;
    assign hdr_op    = hdr_op_q;
    assign hdr_len   = hdr_len_q;
    assign dat_valid = dat_valid_q;
    assign dat_byte  = dat_byte_q;
    assign dat_last  = dat_last_q;
    assign err_valid = err_valid_q;
    assign err_code  = err_code_q;

endmodule

// File: tb/tb_uart_cmd_decoder.sv
// Scoreboard bench for uart_cmd_decoder: stimulus pushes expected headers, payload
// bytes and errors into queues; a negedge monitor pops and compares on each output event.
module tb_uart_cmd_decoder;

    localparam int TMO = 50;

    typedef struct packed {
        logic [1:0] op;
        logic [7:0] len;
    } hdr_t;

    logic       clk;
    logic       rst;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic       hdr_valid;
    logic       hdr_ready;
    logic [1:0] hdr_op;
    logic [7:0] hdr_len;
    logic       dat_valid;
    logic       dat_ready;
    logic [7:0] dat_byte;
    logic       dat_last;
    logic       err_valid;
    logic [1:0] err_code;

    int checks;
    int errors;

    logic hdr_force;
    logic dat_force;
    logic dat_hold_low;

    hdr_t       hq[$];
    logic [8:0] dq[$];
    logic [1:0] eq[$];

    uart_cmd_decoder #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .rst(rst),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .hdr_valid(hdr_valid), .hdr_ready(hdr_ready), .hdr_op(hdr_op), .hdr_len(hdr_len),
        .dat_valid(dat_valid), .dat_ready(dat_ready), .dat_byte(dat_byte), .dat_last(dat_last),
        .err_valid(err_valid), .err_code(err_code)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    task automatic unexpected(input string nm, input logic [31:0] act);
        checks++;
        errors++;
        $display("FAIL %s actual=%0h expected=no event", nm, act);
    endtask

    task automatic push_hdr(input logic [1:0] op, input logic [7:0] len);
        hdr_t h;
        h.op  = op;
        h.len = len;
        hq.push_back(h);
    endtask

    // Downstream ready generator
    initial begin
        hdr_ready = 1'b0;
        dat_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            hdr_ready = hdr_force ? 1'b1 : 1'($urandom_range(0, 1));
            if (dat_hold_low)   dat_ready = 1'b0;
            else if (dat_force) dat_ready = 1'b1;
            else                dat_ready = ($urandom_range(0, 3) != 0);
        end
    end

    // Monitor: pops the scoreboard on every handshake / error pulse
    initial begin
        hdr_t h;
        logic [8:0] d;
        logic [1:0] e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (hdr_valid && hdr_ready) begin
                    if (hq.size() == 0) unexpected("hdr_unexpected", {22'd0, hdr_op, hdr_len});
                    else begin
                        h = hq.pop_front();
                        chk("hdr_op", 32'(hdr_op), 32'(h.op));
                        chk("hdr_len", 32'(hdr_len), 32'(h.len));
                    end
                end
                if (dat_valid && dat_ready) begin
                    if (dq.size() == 0) unexpected("dat_unexpected", {23'd0, dat_last, dat_byte});
                    else begin
                        d = dq.pop_front();
                        chk("dat_byte", 32'(dat_byte), 32'(d[7:0]));
                        chk("dat_last", 32'(dat_last), 32'(d[8]));
                    end
                end
                if (err_valid) begin
                    if (eq.size() == 0) unexpected("err_unexpected", 32'(err_code));
                    else begin
                        e = eq.pop_front();
                        chk("err_code", 32'(err_code), 32'(e));
                    end
                end
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input int gap);
        int n;
        n = 0;
        in_data  = b;
        in_valid = 1'b1;
        do begin
            @(negedge clk);
            n++;
        end while (!in_ready && n < 2000);
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL send_stall actual=in_ready low expected=byte %0h accepted", b);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while ((hq.size() != 0 || dq.size() != 0 || eq.size() != 0) && n < 5000) begin
            @(posedge clk);
            n++;
        end
        repeat (3) @(posedge clk);
        #1;
        chk("hq_empty", 32'(hq.size()), 32'd0);
        chk("dq_empty", 32'(dq.size()), 32'd0);
        chk("eq_empty", 32'(eq.size()), 32'd0);
    endtask

    // Reference model at command level: expected outputs follow from opcode/length rules
    task automatic issue_cmd(input int kind);
        logic [7:0] b;
        logic [7:0] len;
        int nbytes;
        case (kind)
            0: begin
                push_hdr(2'd0, 8'd0);
                send_byte(8'h01, $urandom_range(0, 3));
            end
            1, 2: begin
                len    = 8'($urandom_range(1, 255));
                nbytes = (int'(len) + 7) / 8;
                push_hdr(2'(kind), len);
                send_byte(8'(kind + 1), $urandom_range(0, 3));
                send_byte(len, $urandom_range(0, 3));
                for (int i = 0; i < nbytes; i++) begin
                    b = 8'($urandom_range(0, 255));
                    dq.push_back({(i == nbytes - 1), b});
                    send_byte(b, $urandom_range(0, 3));
                end
            end
            3: begin
                len = 8'($urandom_range(0, 255));
                push_hdr(2'd3, len);
                send_byte(8'h04, $urandom_range(0, 3));
                send_byte(len, $urandom_range(0, 3));
            end
            4: begin
                do b = 8'($urandom_range(0, 255)); while (b inside {[8'h01:8'h04]});
                eq.push_back(2'd1);
                send_byte(b, $urandom_range(0, 3));
            end
            default: begin
                eq.push_back(2'd2);
                send_byte(8'($urandom_range(2, 3)), $urandom_range(0, 3));
                send_byte(8'h00, $urandom_range(0, 3));
            end
        endcase
    endtask

    initial begin
        int cnt;
        int n;
        checks       = 0;
        errors       = 0;
        hdr_force    = 1'b1;
        dat_force    = 1'b1;
        dat_hold_low = 1'b0;
        in_data      = 8'h00;
        in_valid     = 1'b0;
        rst          = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_outputs", {14'd0, hdr_valid, dat_valid, dat_last, err_valid, err_code, hdr_op, hdr_len, dat_byte}, 32'd0);
        chk("rst_in_ready_held", 32'(in_ready), 32'd1);
        rst = 1'b0;
        repeat (2) begin @(posedge clk); #1; end

        // TAP_RESET: one-cycle header, no payload, no error
        push_hdr(2'd0, 8'd0);
        send_byte(8'h01, 0);
        cnt = 0;
        repeat (5) begin
            @(negedge clk);
            if (hdr_valid) cnt++;
        end
        chk("tap_reset_hdr_cycles", 32'(cnt), 32'd1);
        wait_drain();

        // SHIFT_DR of 12 bits -> two payload bytes
        push_hdr(2'd2, 8'd12);
        dq.push_back({1'b0, 8'hA5});
        dq.push_back({1'b1, 8'h0F});
        send_byte(8'h03, 0);
        send_byte(8'h0C, 1);
        send_byte(8'hA5, 0);
        send_byte(8'h0F, 2);
        wait_drain();
        chk("dr_back_in_op", 32'(in_ready), 32'd1);

        // SHIFT_IR 8 bits with downstream stalled for 20 cycles
        push_hdr(2'd1, 8'd8);
        send_byte(8'h02, 0);
        send_byte(8'h08, 0);
        dat_hold_low = 1'b1;
        repeat (2) begin @(posedge clk); #1; end
        dq.push_back({1'b1, 8'h3C});
        send_byte(8'h3C, 0);
        repeat (20) begin @(posedge clk); #1; end
        chk("ir_pending_valid", 32'(dat_valid), 32'd1);
        // Next command header goes out, but payload is blocked by the pending byte
        push_hdr(2'd1, 8'd16);
        send_byte(8'h02, 0);
        send_byte(8'h10, 0);
        repeat (4) begin @(posedge clk); #1; end
        chk("bp_in_ready_low", 32'(in_ready), 32'd0);
        repeat (TMO + 10) begin @(posedge clk); #1; end
        chk("bp_in_ready_still_low", 32'(in_ready), 32'd0);
        dq.push_back({1'b0, 8'h5A});
        dq.push_back({1'b1, 8'h6B});
        dat_hold_low = 1'b0;
        send_byte(8'h5A, 0);
        send_byte(8'h6B, 0);
        wait_drain();

        // Unknown opcode followed by RUNTEST
        eq.push_back(2'd1);
        push_hdr(2'd3, 8'd5);
        send_byte(8'h7E, 0);
        send_byte(8'h04, 0);
        send_byte(8'h05, 0);
        wait_drain();
        chk("err_code_held", 32'(err_code), 32'd1);

        // Zero shift length, then a normal opcode
        eq.push_back(2'd2);
        send_byte(8'h02, 0);
        send_byte(8'h00, 0);
        push_hdr(2'd0, 8'd0);
        send_byte(8'h01, 0);
        wait_drain();

        // Randomized command mix with random downstream back-pressure
        hdr_force = 1'b0;
        dat_force = 1'b0;
        for (int k = 0; k < 40; k++) begin
            issue_cmd($urandom_range(0, 5));
        end
        wait_drain();

        // Inter-byte timeout inside DATA
        hdr_force = 1'b1;
        dat_force = 1'b1;
        repeat (2) begin @(posedge clk); #1; end
        push_hdr(2'd2, 8'd16);
        dq.push_back({1'b0, 8'h11});
        eq.push_back(2'd3);
        send_byte(8'h03, 0);
        send_byte(8'h10, 0);
        send_byte(8'h11, 0);
        n = 0;
        while (!err_valid && n < 4 * TMO) begin
            @(posedge clk);
            n++;
            #1;
        end
        chk("timeout_latency", 32'(n), 32'(TMO));
        chk("timeout_back_in_op", 32'(in_ready), 32'd1);
        wait_drain();

        // Reset in the middle of a frame with a payload byte pending
        dat_force    = 1'b0;
        dat_hold_low = 1'b1;
        repeat (2) begin @(posedge clk); #1; end
        push_hdr(2'd2, 8'd16);
        dq.push_back({1'b0, 8'h22});
        send_byte(8'h03, 0);
        send_byte(8'h10, 0);
        send_byte(8'h22, 0);
        repeat (3) begin @(posedge clk); #1; end
        chk("pre_reset_pending", 32'(dat_valid), 32'd1);
        rst = 1'b1;
        #2;
        chk("midframe_rst_outputs", {14'd0, hdr_valid, dat_valid, dat_last, err_valid, err_code, hdr_op, hdr_len, dat_byte}, 32'd0);
        hq.delete();
        dq.delete();
        eq.delete();
        @(posedge clk);
        #1;
        rst          = 1'b0;
        dat_hold_low = 1'b0;
        dat_force    = 1'b1;
        push_hdr(2'd0, 8'd0);
        send_byte(8'h01, 0);
        wait_drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
